// File: rtl/viterbi_pkg.sv
// Code constants and FSM states shared by the K=5 rate-1/2 encoder and the
// decoder's branch-metric and trellis blocks.
package viterbi_pkg;

  localparam int K = 5;
  localparam int MEM = K - 1;

  // Tap vectors indexed by window position; bit K-1 is the newest bit.
  localparam logic [K-1:0] G0 = 5'b11001;
  localparam logic [K-1:0] G1 = 5'b10111;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;

  function automatic logic [K-1:0] make_window(input logic u, input logic [MEM-1:0] sr);
    return {u, sr};
  endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Bit-in / pair-out handshake bundle of the convolutional encoder.
interface conv_encoder_if;

  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] enc_pair;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  // master: the side feeding bits in and draining pairs out
  modport master (
    output in_bit, in_valid, out_ready,
    input  in_ready, enc_pair, out_valid, out_last, busy
  );

  modport slave (
    input  in_bit, in_valid, out_ready,
    output in_ready, enc_pair, out_valid, out_last, busy
  );

endinterface

// File: rtl/conv_parity.sv
// Combinational parity pair for one K-bit window: pair[1] from G0, pair[0] from G1.
module conv_parity
  import viterbi_pkg::*;
(
  input  logic [K-1:0] window,
  output logic [1:0]   pair
);

  logic [K-1:0] tap0;
  logic [K-1:0] tap1;

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_tap
      assign tap0[gi] = window[gi] & G0[gi];
      assign tap1[gi] = window[gi] & G1[gi];
    end
  endgenerate

  assign pair = {^tap0, ^tap1};

endmodule

// File: rtl/conv_encoder.sv
// Framed rate-1/2 K=5 convolutional encoder with zero-tail termination and a
// single-entry output register that can accept and drain in the same cycle.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] enc_pair,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_LEN - 1);
  localparam logic [1:0]    TAIL_LAST = 2'(MEM - 1);

  enc_state_t     state_reg;
  logic [MEM-1:0] sr_reg;
  logic [CW-1:0]  count_reg;
  logic [1:0]     tail_reg;

  logic       slot_free;
  logic       accept;
  logic       tail_step;
  logic       load;
  logic       u;
  logic [K-1:0] window;
  logic [1:0] pair;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && (state_reg != TAIL);
  assign accept    = in_valid && in_ready;
  assign tail_step = (state_reg == TAIL) && slot_free;
  assign load      = accept || tail_step;
  // Tail cycles flush the register with zeros.
  assign u         = accept && in_bit;
  assign window    = make_window(u, sr_reg);
  assign busy      = (state_reg != IDLE) || out_valid;

  conv_parity u_parity (
    .window (window),
    .pair   (pair)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      count_reg <= '0;
      tail_reg  <= '0;
      enc_pair  <= 2'b00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (load) begin
        enc_pair  <= pair;
        out_valid <= 1'b1;
        out_last  <= tail_step && (tail_reg == TAIL_LAST);
        sr_reg    <= {u, sr_reg[MEM-1:1]};
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            count_reg <= CW'(1);
            tail_reg  <= '0;
            state_reg <= (FRAME_LEN == 1) ? TAIL : DATA;
          end
        end
        DATA: begin
          if (accept) begin
            if (count_reg == LAST_CNT) begin
              count_reg <= '0;
              state_reg <= TAIL;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end
        end
        TAIL: begin
          if (slot_free) begin
            tail_reg <= tail_reg + 2'd1;
            if (tail_reg == TAIL_LAST) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
